// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage plus the IF/ID pipeline register.
//
// Holds the PC and drives the instruction-memory address. Picks the next PC from, in order:
// an EX-stage taken branch, a load-use stall, an ID-stage redirect (j/jal, jr/jalr, IRQ,
// exception), or sequential PC+4. It presents the fetched instruction, its PC+4 and a
// supervised flag to the ID stage.
//
// Optional feature: define FETCH_PERF_EN to add the perf_fetched/perf_flushed counters.
//
// Ports
//   clk, rst_n        clock; asynchronous active-low reset
//   stall             hold PC and IF/ID (load-use hazard)
//   pc_src            ID redirect select: 000 seq, 001 j/jal, 010 jr/jalr, 011 IRQ, 100 exc
//   jump_index        instr[25:0] of the ID-stage instruction
//   jr_target         forwarded rs value for jr/jalr
//   branch_taken      EX-stage branch resolved taken
//   branch_target     EX-stage branch target
//   imem_addr         instruction-memory address (= pc)
//   imem_rdata        instruction at imem_addr, same cycle
//   if_id_instr       registered instruction for ID (0 for a bubble)
//   if_id_pc4         registered PC+4 of that instruction
//   if_id_valid       0 = bubble
//   perf_fetched      [FETCH_PERF_EN] cycles that fetched sequentially
//   perf_flushed      [FETCH_PERF_EN] cycles that flushed IF/ID (branch or redirect)
//   supervised        kernel-mode flag of the ID instruction; 1 for a bubble
module fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h8000_0000,
    parameter logic [31:0] IRQ_VECTOR = 32'h8000_0004,
    parameter logic [31:0] EXC_VECTOR = 32'h8000_0008
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic [2:0]  pc_src,
    input  logic [25:0] jump_index,
    input  logic [31:0] jr_target,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc4,
    output logic        if_id_valid,
`ifdef FETCH_PERF_EN
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_flushed,
`endif
    output logic        supervised
);

    logic [31:0] pc;
    logic [31:0] pc4;
    logic        redirect;
    logic [31:0] redirect_target;

    assign pc4       = pc + 32'd4;
    assign imem_addr = pc;

    // Bubbles never take an IRQ, so they report kernel mode.
    assign supervised = if_id_valid ? if_id_pc4[31] : 1'b1;

    // ID-stage redirect decode. Only a valid ID instruction may redirect; codes 101-111
    // fall through to sequential fetch.
    always_comb begin
        redirect        = 1'b0;
        redirect_target = pc4;
        if (if_id_valid) begin
            case (pc_src)
                3'b001: begin
                    redirect        = 1'b1;
                    redirect_target = {if_id_pc4[31:28], jump_index, 2'b00};
                end
                3'b010: begin
                    // A user-mode jr cannot reach kernel space; the low two bits are forced 0.
                    redirect        = 1'b1;
                    redirect_target = jr_target & {if_id_pc4[31], {29{1'b1}}, 2'b00};
                end
                3'b011: begin
                    redirect        = 1'b1;
                    redirect_target = IRQ_VECTOR;
                end
                3'b100: begin
                    redirect        = 1'b1;
                    redirect_target = EXC_VECTOR;
                end
                default: begin
                    redirect        = 1'b0;
                    redirect_target = pc4;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc          <= RESET_PC;
            if_id_instr <= 32'd0;
            if_id_pc4   <= RESET_PC;
            if_id_valid <= 1'b0;
        end else if (branch_taken) begin
            // Wrong-path flush: the branch overrides both a stall and an ID redirect.
            pc          <= branch_target;
            if_id_instr <= 32'd0;
            if_id_valid <= 1'b0;
        end else if (stall) begin
            pc          <= pc;
        end else if (redirect) begin
            pc          <= redirect_target;
            if_id_instr <= 32'd0;
            if_id_valid <= 1'b0;
        end else begin
            pc          <= pc4;
            if_id_instr <= imem_rdata;
            if_id_pc4   <= pc4;
            if_id_valid <= 1'b1;
        end
    end

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetched <= 32'd0;
            perf_flushed <= 32'd0;
        end else if (branch_taken) begin
            perf_flushed <= perf_flushed + 32'd1;
        end else if (!stall) begin
            if (redirect) begin
                perf_flushed <= perf_flushed + 32'd1;
            end else begin
                perf_fetched <= perf_fetched + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios followed by randomized traffic, all checked
// against a cycle-level reference model of the fetch rules.
module tb_fetch_stage;

    localparam logic [31:0] RESET_PC   = 32'h8000_0000;
    localparam logic [31:0] IRQ_VECTOR = 32'h8000_0004;
    localparam logic [31:0] EXC_VECTOR = 32'h8000_0008;
    // Instruction memory contents: word at address a is a ^ IMEM_KEY.
    localparam logic [31:0] IMEM_KEY   = 32'hA408_0001;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic [2:0]  pc_src = 3'b000;
    logic [25:0] jump_index = 26'd0;
    logic [31:0] jr_target = 32'd0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = 32'd0;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc4;
    logic        if_id_valid;
    logic        supervised;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_flushed;
`endif

    int errors = 0;
    int checks = 0;

    // Reference state.
    logic [31:0] m_pc, m_instr, m_pc4;
    logic        m_valid;
    logic [31:0] m_fetched, m_flushed;

    assign imem_rdata = imem_addr ^ IMEM_KEY;

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall         (stall),
        .pc_src        (pc_src),
        .jump_index    (jump_index),
        .jr_target     (jr_target),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .if_id_instr   (if_id_instr),
        .if_id_pc4     (if_id_pc4),
        .if_id_valid   (if_id_valid),
`ifdef FETCH_PERF_EN
        .perf_fetched  (perf_fetched),
        .perf_flushed  (perf_flushed),
`endif
        .supervised    (supervised)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc      = RESET_PC;
        m_instr   = 32'd0;
        m_pc4     = RESET_PC;
        m_valid   = 1'b0;
        m_fetched = 32'd0;
        m_flushed = 32'd0;
    endtask

    // One clock of the fetch rules, applied to the current inputs.
    task automatic model_step();
        logic [31:0] tgt;
        logic        is_redirect;
        is_redirect = m_valid && (pc_src >= 3'd1) && (pc_src <= 3'd4);
        if (branch_taken) begin
            m_pc = branch_target; m_instr = 0; m_valid = 0; m_flushed++;
        end else if (stall) begin
            // frozen
        end else if (is_redirect) begin
            if (pc_src == 3'd1) tgt = (m_pc4 & 32'hF000_0000) | ({6'd0, jump_index} * 4);
            else if (pc_src == 3'd2) begin
                tgt = (jr_target / 4) * 4;
                if (!m_pc4[31]) tgt = tgt % 32'h8000_0000;
            end
            else if (pc_src == 3'd3) tgt = IRQ_VECTOR;
            else tgt = EXC_VECTOR;
            m_pc = tgt; m_instr = 0; m_valid = 0; m_flushed++;
        end else begin
            m_instr = m_pc ^ IMEM_KEY; m_pc4 = m_pc + 4; m_valid = 1; m_pc = m_pc + 4;
            m_fetched++;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".addr"}, imem_addr, m_pc);
        chk({tag, ".instr"}, if_id_instr, m_instr);
        chk({tag, ".pc4"}, if_id_pc4, m_pc4);
        chk({tag, ".valid"}, {31'd0, if_id_valid}, {31'd0, m_valid});
        chk({tag, ".sup"}, {31'd0, supervised}, {31'd0, m_valid ? m_pc4[31] : 1'b1});
`ifdef FETCH_PERF_EN
        chk({tag, ".pfetch"}, perf_fetched, m_fetched);
        chk({tag, ".pflush"}, perf_flushed, m_flushed);
`endif
    endtask

    task automatic drive(input logic bt, input logic [31:0] btgt, input logic st,
                         input logic [2:0] src, input logic [25:0] ji, input logic [31:0] jr);
        branch_taken = bt; branch_target = btgt; stall = st;
        pc_src = src; jump_index = ji; jr_target = jr;
    endtask

    // Apply current inputs for one clock, then compare 1 time unit after the edge.
    task automatic cycle(input string tag);
        model_step();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    initial begin
        model_reset();
        // T1: reset and first fetch.
        #12;
        check_all("rst");
        @(posedge clk); #1;
        rst_n = 1'b1;
        check_all("t1_addr");
        chk("t1_addr_k", imem_addr, 32'h8000_0000);
        drive(0, 0, 0, 3'b000, 0, 0);
        cycle("t1");
        chk("t1_instr_k", if_id_instr, 32'h2408_0001);
        chk("t1_pc4_k", if_id_pc4, 32'h8000_0004);
        chk("t1_next_k", imem_addr, 32'h8000_0004);

        // T2: get a valid instruction with pc4=0040_0010 into ID, then j.
        drive(1, 32'h0040_000C, 0, 3'b000, 0, 0);
        cycle("t2_br");
        drive(0, 0, 0, 3'b000, 0, 0);
        cycle("t2_f");
        drive(0, 0, 0, 3'b001, 26'h010_0008, 0);
        cycle("t2_j");
        chk("t2_pc_k", imem_addr, 32'h0040_0020);
        chk("t2_sup_k", {31'd0, supervised}, 32'd1);

        // T3: user-mode jr to a kernel address is clamped into user space.
        drive(0, 0, 0, 3'b000, 0, 0);
        cycle("t3_f");
        drive(0, 0, 0, 3'b010, 0, 32'h8000_1237);
        cycle("t3_jr");
        chk("t3_pc_k", imem_addr, 32'h0000_1234);

        // T4: stall holds a pending j for two cycles, then the redirect is taken.
        drive(0, 0, 0, 3'b000, 0, 0);
        cycle("t4_f");
        drive(0, 0, 1, 3'b001, 26'h000_0100, 0);
        cycle("t4_s1");
        cycle("t4_s2");
        chk("t4_hold_k", imem_addr, 32'h0000_1238);
        drive(0, 0, 0, 3'b001, 26'h000_0100, 0);
        cycle("t4_j");
        chk("t4_pc_k", imem_addr, 32'h0000_0400);

        // T6: user instruction in ID takes an IRQ.
        drive(0, 0, 0, 3'b000, 0, 0);
        cycle("t6_f");
        drive(0, 0, 0, 3'b011, 0, 0);
        cycle("t6_irq");
        chk("t6_pc_k", imem_addr, 32'h8000_0004);

        // T5: branch beats a simultaneous stall and IRQ redirect.
        drive(0, 0, 0, 3'b000, 0, 0);
        cycle("t5_f");
        drive(1, 32'h0040_0100, 1, 3'b011, 0, 0);
        cycle("t5_br");
        chk("t5_pc_k", imem_addr, 32'h0040_0100);
        chk("t5_valid_k", {31'd0, if_id_valid}, 32'd0);

        // Exception vector and reserved pc_src codes.
        drive(0, 0, 0, 3'b000, 0, 0);
        cycle("ex_f");
        drive(0, 0, 0, 3'b111, 0, 0);
        cycle("rsv");
        drive(0, 0, 0, 3'b100, 0, 0);
        cycle("exc");

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 7) == 0), $urandom, ($urandom_range(0, 3) == 0),
                  3'($urandom_range(0, 7)), 26'($urandom), $urandom);
            cycle("rnd");
        end

        // PC wrap at the top of the address space.
        drive(1, 32'hFFFF_FFFC, 0, 3'b000, 0, 0);
        cycle("wrap_br");
        drive(0, 0, 0, 3'b000, 0, 0);
        cycle("wrap_f");

        // Asynchronous reset mid-operation.
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("arst");
        @(posedge clk); #1;
        check_all("arst_hold");
        rst_n = 1'b1;
        cycle("arst_rel");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
